// File: rtl/bridge_cmd_pkg.sv
// Shared definitions for the host command handler: command, result and
// status codes, FSM states and the decoded-operation type.
package bridge_cmd_pkg;

    localparam logic [15:0] CMD_STATUS       = 16'h0000;
    localparam logic [15:0] CMD_RESET_ENTER  = 16'h0010;
    localparam logic [15:0] CMD_RESET_EXIT   = 16'h0011;
    localparam logic [15:0] CMD_SLOT_UPDATE  = 16'h008A;
    localparam logic [15:0] CMD_ALL_COMPLETE = 16'h008F;
    localparam logic [15:0] CMD_RTC          = 16'h0090;

    localparam logic [15:0] RES_OK      = 16'h0000;
    localparam logic [15:0] RES_UNKNOWN = 16'h0001;
    localparam logic [15:0] RES_TIMEOUT = 16'h0002;

    localparam logic [31:0] STATUS_BOOTING = 32'h0000_0001;
    localparam logic [31:0] STATUS_RUNNING = 32'h0000_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_EXEC,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_STATUS,
        OP_RESET_ENTER,
        OP_RESET_EXIT,
        OP_SLOT_UPDATE,
        OP_ALL_COMPLETE,
        OP_RTC,
        OP_UNKNOWN
    } op_t;

    function automatic op_t decode_cmd(input logic [15:0] word);
        op_t op;
        case (word)
            CMD_STATUS:       op = OP_STATUS;
            CMD_RESET_ENTER:  op = OP_RESET_ENTER;
            CMD_RESET_EXIT:   op = OP_RESET_EXIT;
            CMD_SLOT_UPDATE:  op = OP_SLOT_UPDATE;
            CMD_ALL_COMPLETE: op = OP_ALL_COMPLETE;
            CMD_RTC:          op = OP_RTC;
            default:          op = OP_UNKNOWN;
        endcase
        return op;
    endfunction

    // Word 0 sits in the MSBs of the 128-bit parameter block.
    function automatic logic [31:0] param_word(input logic [127:0] p, input logic [1:0] n);
        logic [31:0] w;
        case (n)
            2'd0:    w = p[127:96];
            2'd1:    w = p[95:64];
            2'd2:    w = p[63:32];
            default: w = p[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bridge_driver_if.sv
// Command channel between the host driver and the command handler.
// valid/word/param come from the driver; ack, progress, done, result and
// response come back from the handler (ack and done are one-cycle pulses).
interface bridge_driver_if;
    logic         valid;
    logic [15:0]  word;
    logic [127:0] param;
    logic         ack;
    logic [15:0]  progress;
    logic         done;
    logic [15:0]  result;
    logic [127:0] response;

    modport master (
        output valid, word, param,
        input  ack, progress, done, result, response
    );

    modport slave (
        input  valid, word, param,
        output ack, progress, done, result, response
    );
endinterface

// File: rtl/bridge_host_cmd_handler.sv
// Host command handler: accepts one command at a time, acknowledges it,
// executes it (optionally waiting for core boot) and reports completion.
module bridge_host_cmd_handler
    import bridge_cmd_pkg::*;
#(
    parameter logic [15:0] WAIT_TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    bridge_driver_if.slave cmd,
    input  logic        core_ready,
    output logic        in_reset,
    output logic        slot_upd_valid,
    output logic [15:0] slot_upd_id,
    output logic [31:0] slot_upd_size,
    output logic        slot_all_complete,
    output logic        rtc_valid,
    output logic [31:0] rtc_epoch,
    output logic [31:0] rtc_date,
    output logic [31:0] rtc_time,
    output state_t      dbg_state
);

    state_t        r_state;
    logic [15:0]   r_word;
    logic [31:0]   r_pw0;
    logic [31:0]   r_pw1;
    logic [31:0]   r_pw2;
    op_t           r_op;
    logic          r_exec_dec;
    logic [15:0]   r_wait_cnt;
    logic [15:0]   r_result;
    logic [127:0]  r_response;
    logic          r_in_reset;
    logic          r_slot_upd_valid;
    logic [15:0]   r_slot_upd_id;
    logic [31:0]   r_slot_upd_size;
    logic          r_slot_all_complete;
    logic          r_rtc_valid;
    logic [31:0]   r_rtc_epoch;
    logic [31:0]   r_rtc_date;
    logic [31:0]   r_rtc_time;

    state_t        w_next_state;
    logic [15:0]   w_done_result;
    logic [127:0]  w_done_response;

    // EXEC spends its first cycle registering the decode and acts in the
    // second, giving a fixed four-cycle valid-to-done latency.
    always_comb begin
        w_next_state    = r_state;
        w_done_result   = RES_OK;
        w_done_response = '0;
        case (r_state)
            ST_IDLE: begin
                if (cmd.valid) w_next_state = ST_ACK;
            end
            ST_ACK: w_next_state = ST_EXEC;
            ST_EXEC: begin
                if (r_exec_dec) begin
                    case (r_op)
                        OP_RESET_EXIT: w_next_state = ST_WAIT;
                        OP_STATUS: begin
                            w_next_state    = ST_DONE;
                            w_done_response = {((r_in_reset || !core_ready) ?
                                                STATUS_BOOTING : STATUS_RUNNING), 96'h0};
                        end
                        OP_UNKNOWN: begin
                            w_next_state  = ST_DONE;
                            w_done_result = RES_UNKNOWN;
                        end
                        default: w_next_state = ST_DONE;
                    endcase
                end
            end
            ST_WAIT: begin
                if (core_ready) begin
                    w_next_state = ST_DONE;
                end else if (r_wait_cnt == WAIT_TIMEOUT) begin
                    w_next_state  = ST_DONE;
                    w_done_result = RES_TIMEOUT;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state             <= ST_IDLE;
            r_word              <= '0;
            r_pw0               <= '0;
            r_pw1               <= '0;
            r_pw2               <= '0;
            r_op                <= OP_STATUS;
            r_exec_dec          <= 1'b0;
            r_wait_cnt          <= '0;
            r_result            <= '0;
            r_response          <= '0;
            r_in_reset          <= 1'b1;
            r_slot_upd_valid    <= 1'b0;
            r_slot_upd_id       <= '0;
            r_slot_upd_size     <= '0;
            r_slot_all_complete <= 1'b0;
            r_rtc_valid         <= 1'b0;
            r_rtc_epoch         <= '0;
            r_rtc_date          <= '0;
            r_rtc_time          <= '0;
        end else begin
            r_state             <= w_next_state;
            r_slot_upd_valid    <= 1'b0;
            r_slot_all_complete <= 1'b0;
            r_rtc_valid         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd.valid) begin
                        r_word <= cmd.word;
                        r_pw0  <= param_word(cmd.param, 2'd0);
                        r_pw1  <= param_word(cmd.param, 2'd1);
                        r_pw2  <= param_word(cmd.param, 2'd2);
                    end
                end
                ST_ACK: r_exec_dec <= 1'b0;
                ST_EXEC: begin
                    r_exec_dec <= 1'b1;
                    if (!r_exec_dec) begin
                        r_op <= decode_cmd(r_word);
                    end else begin
                        // Side-effect pulses are registered here so they land in DONE.
                        case (r_op)
                            OP_RESET_ENTER: r_in_reset <= 1'b1;
                            OP_RESET_EXIT: begin
                                r_in_reset <= 1'b0;
                                r_wait_cnt <= '0;
                            end
                            OP_SLOT_UPDATE: begin
                                r_slot_upd_valid <= 1'b1;
                                r_slot_upd_id    <= r_pw0[15:0];
                                r_slot_upd_size  <= r_pw1;
                            end
                            OP_ALL_COMPLETE: r_slot_all_complete <= 1'b1;
                            OP_RTC: begin
                                r_rtc_valid <= 1'b1;
                                r_rtc_epoch <= r_pw0;
                                r_rtc_date  <= r_pw1;
                                r_rtc_time  <= r_pw2;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (w_next_state == ST_WAIT && r_wait_cnt != 16'hFFFF)
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                end
                default: ;
            endcase
            if (w_next_state == ST_DONE) begin
                r_result   <= w_done_result;
                r_response <= w_done_response;
            end
        end
    end

    assign cmd.ack           = (r_state == ST_ACK);
    assign cmd.done          = (r_state == ST_DONE);
    assign cmd.progress      = (r_state == ST_WAIT) ? r_wait_cnt : 16'h0000;
    assign cmd.result        = r_result;
    assign cmd.response      = r_response;
    assign in_reset          = r_in_reset;
    assign slot_upd_valid    = r_slot_upd_valid;
    assign slot_upd_id       = r_slot_upd_id;
    assign slot_upd_size     = r_slot_upd_size;
    assign slot_all_complete = r_slot_all_complete;
    assign rtc_valid         = r_rtc_valid;
    assign rtc_epoch         = r_rtc_epoch;
    assign rtc_date          = r_rtc_date;
    assign rtc_time          = r_rtc_time;
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_bridge_host_cmd_handler.sv
// Directed bench for bridge_host_cmd_handler: a driver issues commands and
// pushes expected completions; a monitor pops and checks them on each done.
module tb_bridge_host_cmd_handler;
  import bridge_cmd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        core_ready;
  logic        in_reset;
  logic        slot_upd_valid;
  logic [15:0] slot_upd_id;
  logic [31:0] slot_upd_size;
  logic        slot_all_complete;
  logic        rtc_valid;
  logic [31:0] rtc_epoch;
  logic [31:0] rtc_date;
  logic [31:0] rtc_time;
  state_t      dbg_state;

  bridge_driver_if cmd_if();

  bridge_host_cmd_handler #(.WAIT_TIMEOUT(16'd8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd               (cmd_if),
    .core_ready        (core_ready),
    .in_reset          (in_reset),
    .slot_upd_valid    (slot_upd_valid),
    .slot_upd_id       (slot_upd_id),
    .slot_upd_size     (slot_upd_size),
    .slot_all_complete (slot_all_complete),
    .rtc_valid         (rtc_valid),
    .rtc_epoch         (rtc_epoch),
    .rtc_date          (rtc_date),
    .rtc_time          (rtc_time),
    .dbg_state         (dbg_state)
  );

  typedef struct packed {
    logic [15:0]  result;
    logic [127:0] response;
    logic [2:0]   pulses;
    logic [15:0]  id;
    logic [31:0]  size;
    logic [31:0]  epoch;
    logic [31:0]  date;
    logic [31:0]  tme;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the held slot/RTC values after each command.
  logic [15:0] m_id    = '0;
  logic [31:0] m_size  = '0;
  logic [31:0] m_epoch = '0;
  logic [31:0] m_date  = '0;
  logic [31:0] m_time  = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] r, input logic [127:0] resp, input logic [2:0] pul);
    exp_t e;
    e.result   = r;
    e.response = resp;
    e.pulses   = pul;
    e.id       = m_id;
    e.size     = m_size;
    e.epoch    = m_epoch;
    e.date     = m_date;
    e.tme      = m_time;
    exp_q.push_back(e);
  endtask

  // Issues one command; checks ack at +1 and, for non-WAIT commands, done at +4.
  task automatic send(input logic [15:0] w, input logic [127:0] p, input int hold, input bit is_wait);
    int last;
    last = is_wait ? 1 : 4;
    @(negedge clk);
    cmd_if.valid = 1'b1;
    cmd_if.word  = w;
    cmd_if.param = p;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c >= hold) cmd_if.valid = 1'b0;
      check("ack_timing", cmd_if.ack, (c == 1));
      if (!is_wait) check("done_timing", cmd_if.done, (c == 4));
    end
  endtask

  task automatic wait_state(input state_t st, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (dbg_state == st) hit = 1'b1;
    end
    check("reach_state", hit, 1'b1);
  endtask

  // Monitor: every done pops one expectation; pulses outside done are errors.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_if.done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          mon_e = exp_q.pop_front();
          check("result", cmd_if.result, mon_e.result);
          check("response", cmd_if.response, mon_e.response);
          check("pulses", {slot_upd_valid, slot_all_complete, rtc_valid}, mon_e.pulses);
          check("progress_done", cmd_if.progress, 16'h0);
          check("slot_id", slot_upd_id, mon_e.id);
          check("slot_size", slot_upd_size, mon_e.size);
          check("rtc_epoch", rtc_epoch, mon_e.epoch);
          check("rtc_date", rtc_date, mon_e.date);
          check("rtc_time", rtc_time, mon_e.tme);
        end
      end else if (slot_upd_valid || slot_all_complete || rtc_valid) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_pulse: got %b expected 000",
                 {slot_upd_valid, slot_all_complete, rtc_valid});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    core_ready   = 1'b0;
    cmd_if.valid = 1'b0;
    cmd_if.word  = '0;
    cmd_if.param = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", cmd_if.ack, 1'b0);
    check("rst_done", cmd_if.done, 1'b0);
    check("rst_progress", cmd_if.progress, 16'h0);
    check("rst_result", cmd_if.result, 16'h0);
    check("rst_response", cmd_if.response, 128'h0);
    check("rst_in_reset", in_reset, 1'b1);
    check("rst_pulses", {slot_upd_valid, slot_all_complete, rtc_valid}, 3'b000);
    check("rst_slot", {slot_upd_id, slot_upd_size}, 48'h0);
    check("rst_rtc", {rtc_epoch, rtc_date, rtc_time}, 96'h0);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;

    // Status while core held in reset.
    push_exp(RES_OK, {STATUS_BOOTING, 96'h0}, 3'b000);
    send(CMD_STATUS, 128'h0, 1, 1'b0);

    // Reset-exit, core_ready arrives in the fifth WAIT cycle.
    push_exp(RES_OK, 128'h0, 3'b000);
    send(CMD_RESET_EXIT, 128'h0, 1, 1'b1);
    wait_state(ST_WAIT, 10);
    check("exit_in_reset", in_reset, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("wait_progress", cmd_if.progress, k[15:0]);
      if (k == 4) core_ready = 1'b1;
      @(negedge clk);
    end

    // Status running; valid held high across ACK/EXEC must not re-trigger.
    push_exp(RES_OK, {STATUS_RUNNING, 96'h0}, 3'b000);
    send(CMD_STATUS, 128'h0, 4, 1'b0);

    m_id   = 16'h0007;
    m_size = 32'h0000_1000;
    push_exp(RES_OK, 128'h0, 3'b100);
    send(CMD_SLOT_UPDATE, {32'h0000_0007, 32'h0000_1000, 64'h0}, 1, 1'b0);

    push_exp(RES_UNKNOWN, 128'h0, 3'b000);
    send(16'h1234, {32'hFFFF_FFFF, 32'h1111_2222, 64'h3}, 1, 1'b0);

    push_exp(RES_OK, 128'h0, 3'b010);
    send(CMD_ALL_COMPLETE, 128'h0, 1, 1'b0);

    m_epoch = 32'h6553_F100;
    m_date  = 32'h2024_0115;
    m_time  = 32'h0012_3456;
    push_exp(RES_OK, 128'h0, 3'b001);
    send(CMD_RTC, {32'h6553_F100, 32'h2024_0115, 32'h0012_3456, 32'hDEAD_BEEF}, 1, 1'b0);

    m_id   = 16'h1234;
    m_size = 32'h0000_0055;
    push_exp(RES_OK, 128'h0, 3'b100);
    send(CMD_SLOT_UPDATE, {32'hABCD_1234, 32'h0000_0055, 64'hFFFF}, 1, 1'b0);

    push_exp(RES_OK, 128'h0, 3'b000);
    send(CMD_RESET_ENTER, 128'h0, 1, 1'b0);
    check("enter_in_reset", in_reset, 1'b1);

    // core_ready is high but the core is held in reset, so still booting.
    push_exp(RES_OK, {STATUS_BOOTING, 96'h0}, 3'b000);
    send(CMD_STATUS, 128'h0, 1, 1'b0);

    // Timeout: progress runs 0..8 then done with TIMEOUT.
    core_ready = 1'b0;
    push_exp(RES_TIMEOUT, 128'h0, 3'b000);
    send(CMD_RESET_EXIT, 128'h0, 1, 1'b1);
    wait_state(ST_WAIT, 10);
    for (int k = 0; k < 9; k++) begin
      check("timeout_progress", cmd_if.progress, k[15:0]);
      @(negedge clk);
    end
    @(negedge clk);
    check("timeout_in_reset", in_reset, 1'b0);

    push_exp(RES_OK, {STATUS_BOOTING, 96'h0}, 3'b000);
    send(CMD_STATUS, 128'h0, 1, 1'b0);

    // Reset asserted in WAIT aborts the command with no completion.
    send(CMD_RESET_EXIT, 128'h0, 1, 1'b1);
    wait_state(ST_WAIT, 10);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    m_id    = '0;
    m_size  = '0;
    m_epoch = '0;
    m_date  = '0;
    m_time  = '0;
    check("abort_in_reset", in_reset, 1'b1);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_progress", cmd_if.progress, 16'h0);
    check("abort_slot_id", slot_upd_id, m_id);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_in_reset_held", in_reset, 1'b1);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
